sum_to_bcd: RTL

Sequential binary-to-BCD converter placed directly downstream of the 8-bit adder. It consumes the 9-bit sum and produces three decimal digits for the number-display blocks. It uses shift-and-add-3 (double-dabble), one bit per clock, so the gate count stays small; in-game logic area matters more than latency. The last result is held stable while a new conversion runs, so displays never flicker.

---
 rtl/sum_to_bcd_pkg.sv | 17 +
 rtl/bcd_digit_adj.sv | 15 +
 rtl/sum_to_bcd.sv | 104 ++++++++++
 3 files changed

// File: rtl/sum_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package sum_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  // Bit-count register must be able to hold IN_W itself.
  function automatic int cnt_w(input int in_w);
    return $clog2(in_w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
// Purely combinational, no backpressure.
module bcd_digit_adj
  import sum_to_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= BCD_DIGIT_W'(5)) dout = din + BCD_DIGIT_W'(3);
  end

endmodule

// File: rtl/sum_to_bcd.sv
// Binary adder sum to DIGITS BCD digits, one bit per clock (done IN_W+1 cycles after start).
// start is ignored while busy; bcd holds the previous result until the new one lands.
module sum_to_bcd
  import sum_to_bcd_pkg::*;
#(
  parameter int IN_W   = 9,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [IN_W-1:0]               bin,
  output logic                          busy,
  output logic                          done,
  output logic                          valid,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int CW = cnt_w(IN_W);
  localparam int SW = BCD_DIGIT_W * DIGITS;
  localparam int TW = SW + IN_W;

  if (10 ** DIGITS <= 2 ** IN_W - 1) begin : g_range_check
    $error("sum_to_bcd: DIGITS too small for IN_W");
  end

  state_t          state, state_nxt;
  logic            load;
  logic [IN_W-1:0] sreg;
  logic [SW-1:0]   scratch;
  logic [SW-1:0]   adj;
  logic [TW-1:0]   sh_nxt;
  logic [CW-1:0]   cnt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Adjusted digits and the remaining binary bits shift as one register.
  assign sh_nxt = {adj, sreg} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      sreg    <= bin;
      scratch <= '0;
      cnt     <= CW'(IN_W);
    end else if (state == SHIFT) begin
      sreg    <= sh_nxt[IN_W-1:0];
      scratch <= sh_nxt[TW-1:IN_W];
      cnt     <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        bcd   <= sh_nxt[TW-1:IN_W];
        valid <= 1'b1;
      end
    end
  end

endmodule
